// File: rtl/cache_sim_pkg.sv
// Shared types, default geometry and helpers for the set-associative cache simulator.
package cache_sim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_PF_CHECK,
        S_FILL,
        S_PF_ISSUE
    } state_t;

    localparam int DEF_WAYS        = 4;
    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_CACHE_BYTES = 32768;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_PF_DEGREE   = 1;
    localparam int DEF_PF_DEPTH    = 4;
    localparam int DEF_CNT_W       = 32;

    // Saturating increment for counters up to 64 bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max;
        max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// Block-address CAM organised as a FIFO ring; a push always lands on the write pointer.
module prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int BLK_W = 28
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BLK_W-1:0] query_blk,
    output logic             match,
    input  logic             invalidate,
    input  logic             push,
    input  logic [BLK_W-1:0] push_blk
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0]            hit_vec;
    logic [DEPTH-1:0][BLK_W-1:0] ent_blk;
    logic [PTR_W-1:0]            wptr;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++)
            hit_vec[i] = ent_valid[i] && (ent_blk[i] == query_blk);
    end

    assign match = |hit_vec;

    // Invalidated slots stay empty until the ring pointer comes back round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_blk   <= '0;
            wptr      <= '0;
        end else begin
            if (invalidate)
                ent_valid <= ent_valid & ~hit_vec;
            if (push) begin
                ent_valid[wptr] <= 1'b1;
                ent_blk[wptr]   <= push_blk;
                wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache_sim.sv
// Set-associative cache simulator core: tag/valid/age-LRU state, access FSM,
// next-line prefetch issue and saturating hit/miss statistics.
module set_assoc_cache_sim
    import cache_sim_pkg::*;
#(
    parameter int WAYS        = DEF_WAYS,
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int CACHE_BYTES = DEF_CACHE_BYTES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int PF_DEGREE   = DEF_PF_DEGREE,
    parameter int PF_DEPTH    = DEF_PF_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_valid,
    output logic              trace_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              clear_stats,
    output logic              access_done,
    output logic              access_hit,
    output logic              access_pf_hit,
    output logic [CNT_W-1:0]  cache_hit_count,
    output logic [CNT_W-1:0]  cache_miss_count,
    output logic [CNT_W-1:0]  prefetch_hit_count
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int SETS  = CACHE_BYTES / (BLOCK_BYTES * WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int BLK_W = ADDR_W - OFF_W;
    localparam int TAG_W = BLK_W - IDX_W;
    localparam int AGE_W = $clog2(WAYS);

    state_t            state, state_nxt;
    logic [BLK_W-1:0]  blk, cand, probe;
    logic [2:0]        k;
    logic              pf_flag;
    logic [WAYS-1:0]   valid [SETS];
    logic [TAG_W-1:0]  tags  [SETS][WAYS];
    logic [AGE_W-1:0]  age   [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  ptag;
    logic [WAYS-1:0]   hit_vec;
    logic [AGE_W-1:0]  hit_way, victim, touch_way;
    logic              accept, cache_hit, pf_match, pf_push, touch, done_nxt;
    logic              unused_offset;

    assign unused_offset = ^mem_addr[OFF_W-1:0];
    assign accept = trace_valid & trace_ready;
    assign cand   = blk + BLK_W'(k);
    // One tag port serves both the demand lookup and the prefetch residency query.
    assign probe  = (state == S_PF_ISSUE) ? cand : blk;
    assign idx    = probe[IDX_W-1:0];
    assign ptag   = probe[BLK_W-1:IDX_W];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[idx][w] && (tags[idx][w] == ptag);
            if (age[idx][w] == AGE_W'(WAYS - 1))
                victim = AGE_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])
                hit_way = AGE_W'(w);
            if (!valid[idx][w])
                victim = AGE_W'(w);
        end
    end

    assign cache_hit = |hit_vec;
    assign touch     = ((state == S_LOOKUP) && cache_hit) || (state == S_FILL);
    assign touch_way = (state == S_FILL) ? victim : hit_way;
    assign pf_push   = (state == S_PF_ISSUE) && !cache_hit && !pf_match;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_LOOKUP;
            S_LOOKUP:   state_nxt = cache_hit ? S_IDLE : S_PF_CHECK;
            S_PF_CHECK: state_nxt = S_FILL;
            S_FILL:     state_nxt = (PF_DEGREE == 0) ? S_IDLE : S_PF_ISSUE;
            S_PF_ISSUE: if (k == 3'(PF_DEGREE)) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign done_nxt = (state != S_IDLE) && (state_nxt == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            trace_ready   <= 1'b0;
            blk           <= '0;
            k             <= 3'd1;
            pf_flag       <= 1'b0;
            access_done   <= 1'b0;
            access_hit    <= 1'b0;
            access_pf_hit <= 1'b0;
        end else begin
            state         <= state_nxt;
            trace_ready   <= (state_nxt == S_IDLE);
            if (accept) begin
                blk     <= mem_addr[ADDR_W-1:OFF_W];
                pf_flag <= 1'b0;
            end
            if (state == S_PF_CHECK)
                pf_flag <= pf_match;
            k             <= (state == S_PF_ISSUE) ? k + 3'd1 : 3'd1;
            access_done   <= done_nxt;
            access_hit    <= done_nxt && (state == S_LOOKUP);
            access_pf_hit <= done_nxt && pf_flag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_hit_count    <= '0;
            cache_miss_count   <= '0;
            prefetch_hit_count <= '0;
        end else if (clear_stats) begin
            cache_hit_count    <= '0;
            cache_miss_count   <= '0;
            prefetch_hit_count <= '0;
        end else begin
            if ((state == S_LOOKUP) && cache_hit)
                cache_hit_count <= CNT_W'(sat_inc(64'(cache_hit_count), CNT_W));
            if (state == S_PF_CHECK) begin
                cache_miss_count <= CNT_W'(sat_inc(64'(cache_miss_count), CNT_W));
                if (pf_match)
                    prefetch_hit_count <= CNT_W'(sat_inc(64'(prefetch_hit_count), CNT_W));
            end
        end
    end

    // Age-LRU touch: ways younger than the touched way age by one, touched way becomes 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= AGE_W'(w);
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way)
                    age[idx][w] <= '0;
                else if (age[idx][w] < age[idx][touch_way])
                    age[idx][w] <= age[idx][w] + AGE_W'(1);
            end
            if (state == S_FILL)
                valid[idx][touch_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL)
            tags[idx][victim] <= ptag;
    end

    prefetch_buffer #(
        .DEPTH (PF_DEPTH),
        .BLK_W (BLK_W)
    ) u_pf_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .query_blk  (probe),
        .match      (pf_match),
        .invalidate (state == S_PF_CHECK),
        .push       (pf_push),
        .push_blk   (cand)
    );

endmodule

// File: tb/tb_set_assoc_cache_sim.sv
// Bench for set_assoc_cache_sim: directed vector table, reset/clear sequences,
// and random traces compared against a recency-list cache model.
module tb_set_assoc_cache_sim;
    localparam int WAYS        = 4;
    localparam int BLOCK_BYTES = 16;
    localparam int CACHE_BYTES = 32768;
    localparam int ADDR_W      = 32;
    localparam int PF_DEGREE   = 1;
    localparam int PF_DEPTH    = 4;
    localparam int CNT_W       = 32;
    localparam int SETS        = CACHE_BYTES / (BLOCK_BYTES * WAYS);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trace_valid = 1'b0;
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic              clear_stats = 1'b0;
    logic              access_done, access_hit, access_pf_hit;
    logic [CNT_W-1:0]  cache_hit_count, cache_miss_count, prefetch_hit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    set_assoc_cache_sim #(
        .WAYS(WAYS), .BLOCK_BYTES(BLOCK_BYTES), .CACHE_BYTES(CACHE_BYTES), .ADDR_W(ADDR_W),
        .PF_DEGREE(PF_DEGREE), .PF_DEPTH(PF_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .mem_addr(mem_addr), .clear_stats(clear_stats), .access_done(access_done),
        .access_hit(access_hit), .access_pf_hit(access_pf_hit),
        .cache_hit_count(cache_hit_count), .cache_miss_count(cache_miss_count),
        .prefetch_hit_count(prefetch_hit_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: resident blocks with last-use stamps, prefetch ring of slots.
    bit [27:0] m_res[$];
    longint    m_stamp[$];
    longint    m_time;
    bit [27:0] m_pf[PF_DEPTH];
    bit        m_pfv[PF_DEPTH];
    int        m_wp;
    int        m_hits, m_miss, m_pfh;

    function automatic void model_reset();
        m_res.delete();
        m_stamp.delete();
        m_time = 0;
        for (int i = 0; i < PF_DEPTH; i++) m_pfv[i] = 1'b0;
        m_wp = 0; m_hits = 0; m_miss = 0; m_pfh = 0;
    endfunction

    function automatic bit in_cache(input bit [27:0] b);
        foreach (m_res[i]) if (m_res[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_pf(input bit [27:0] b);
        for (int i = 0; i < PF_DEPTH; i++) if (m_pfv[i] && m_pf[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_access(input bit [27:0] b, output bit hit, output bit pf);
        int cnt, old;
        longint oldest;
        bit [27:0] c;
        m_time++;
        hit = 1'b0;
        pf  = 1'b0;
        foreach (m_res[i]) begin
            if (m_res[i] == b) begin
                m_stamp[i] = m_time;
                hit = 1'b1;
                m_hits++;
                return;
            end
        end
        m_miss++;
        for (int i = 0; i < PF_DEPTH; i++) begin
            if (m_pfv[i] && m_pf[i] == b) begin
                pf = 1'b1;
                m_pfv[i] = 1'b0;
                m_pfh++;
            end
        end
        cnt = 0; old = -1; oldest = 0;
        foreach (m_res[i]) begin
            if ((m_res[i] % SETS) == (b % SETS)) begin
                cnt++;
                if (old < 0 || m_stamp[i] < oldest) begin old = i; oldest = m_stamp[i]; end
            end
        end
        if (cnt == WAYS) begin
            m_res.delete(old);
            m_stamp.delete(old);
        end
        m_res.push_back(b);
        m_stamp.push_back(m_time);
        for (int kk = 1; kk <= PF_DEGREE; kk++) begin
            c = b + 28'(kk);
            if (!in_cache(c) && !in_pf(c)) begin
                m_pf[m_wp]  = c;
                m_pfv[m_wp] = 1'b1;
                m_wp = (m_wp + 1) % PF_DEPTH;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; trace_valid = 1'b0; clear_stats = 1'b0;
        @(negedge clk);
        chk("rst_ready", trace_ready, 0);
        chk("rst_done", access_done, 0);
        chk("rst_hit_cnt", cache_hit_count, 0);
        chk("rst_miss_cnt", cache_miss_count, 0);
        chk("rst_pf_cnt", prefetch_hit_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", trace_ready, 1);
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_access(input logic [31:0] a, input bit eh, input bit ep, input string nm);
        int n;
        n = 0;
        while (!trace_ready && n < 50) begin @(negedge clk); n++; end
        if (!trace_ready) begin
            chk({nm, "_ready_timeout"}, 0, 1);
            return;
        end
        trace_valid = 1'b1;
        mem_addr = a;
        @(posedge clk);
        @(negedge clk);
        trace_valid = 1'b0;
        n = 1;
        while (!access_done && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_latency"}, n, eh ? 2 : 4 + PF_DEGREE);
        chk({nm, "_hit"}, access_hit, eh);
        chk({nm, "_pf_hit"}, access_pf_hit, ep);
        chk({nm, "_ready_at_done"}, trace_ready, 1);
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] addr;
        bit          hit;
        bit          pf;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int eh, em, ep;
        bit bh, bp;
        logic [31:0] a;

        // repeat hit, prefetch hit, set-0 LRU eviction
        tbl.push_back('{1, 32'h0000_0100, 0, 0});
        tbl.push_back('{0, 32'h0000_0100, 1, 0});
        tbl.push_back('{0, 32'h0000_0110, 0, 1});
        tbl.push_back('{0, 32'h0000_0110, 1, 0});
        tbl.push_back('{0, 32'h0000_0000, 0, 0});
        tbl.push_back('{0, 32'h0000_2000, 0, 0});
        tbl.push_back('{0, 32'h0000_4000, 0, 0});
        tbl.push_back('{0, 32'h0000_6000, 0, 0});
        tbl.push_back('{0, 32'h0000_8000, 0, 0});
        tbl.push_back('{0, 32'h0000_0000, 0, 0});
        tbl.push_back('{0, 32'h0000_4000, 1, 0});
        tbl.push_back('{0, 32'h0000_2000, 0, 0});
        // top-of-memory wrap of the prefetch candidate
        tbl.push_back('{1, 32'hFFFF_FFF0, 0, 0});
        tbl.push_back('{0, 32'h0000_0000, 0, 1});
        // ring overwrite: six misses, oldest two prefetches lost
        tbl.push_back('{1, 32'h0001_0000, 0, 0});
        tbl.push_back('{0, 32'h0002_0000, 0, 0});
        tbl.push_back('{0, 32'h0003_0000, 0, 0});
        tbl.push_back('{0, 32'h0004_0000, 0, 0});
        tbl.push_back('{0, 32'h0005_0000, 0, 0});
        tbl.push_back('{0, 32'h0006_0000, 0, 0});
        tbl.push_back('{0, 32'h0001_0010, 0, 0});
        tbl.push_back('{0, 32'h0002_0010, 0, 0});
        tbl.push_back('{0, 32'h0006_0010, 0, 1});

        eh = 0; em = 0; ep = 0;
        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset();
                eh = 0; em = 0; ep = 0;
            end
            do_access(tbl[i].addr, tbl[i].hit, tbl[i].pf, $sformatf("vec%0d", i));
            if (tbl[i].hit) eh++;
            else begin
                em++;
                if (tbl[i].pf) ep++;
            end
            chk($sformatf("vec%0d_hit_cnt", i), cache_hit_count, eh);
            chk($sformatf("vec%0d_miss_cnt", i), cache_miss_count, em);
            chk($sformatf("vec%0d_pf_cnt", i), prefetch_hit_count, ep);
        end

        // reset while issuing the prefetch drops the access entirely
        do_reset();
        trace_valid = 1'b1;
        mem_addr = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        trace_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_miss_cnt", cache_miss_count, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_done", access_done, 0);
        chk("midrst_miss_cnt", cache_miss_count, 0);
        chk("midrst_ready", trace_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", trace_ready, 1);
        do_access(32'h0000_0100, 0, 0, "after_midrst");

        // clear_stats held across a hit: clear wins
        clear_stats = 1'b1;
        do_access(32'h0000_0100, 1, 0, "clear_hit");
        chk("clear_hit_cnt", cache_hit_count, 0);
        chk("clear_miss_cnt", cache_miss_count, 0);
        clear_stats = 1'b0;
        do_access(32'h0000_0100, 1, 0, "post_clear_hit");
        chk("post_clear_hit_cnt", cache_hit_count, 1);
        chk("post_clear_miss_cnt", cache_miss_count, 0);

        // random traces over a few sets and tags against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a = (($urandom % 6) << 13) | (($urandom % 3) << 4) | ($urandom % 16);
            model_access(a[31:4], bh, bp);
            do_access(a, bh, bp, $sformatf("rnd%0d", i));
            repeat ($urandom % 3) @(negedge clk);
        end
        chk("rnd_hit_cnt", cache_hit_count, m_hits);
        chk("rnd_miss_cnt", cache_miss_count, m_miss);
        chk("rnd_pf_cnt", prefetch_hit_count, m_pfh);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
